// File: rtl/fabric_arb_pkg.sv
// Shared types and constants for the fabric request arbiter.
package fabric_arb_pkg;

  // Transaction FSM: one fabric transaction outstanding at a time.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  // The wait counter is never narrower than this.
  localparam int CNT_MIN_W = 8;

  // Counter width able to hold TIMEOUT-1, floored at CNT_MIN_W.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout);
    return (w < CNT_MIN_W) ? CNT_MIN_W : w;
  endfunction

endpackage

// File: rtl/fabric_rr_arbiter.sv
// Combinational round-robin picker: search starts just after last_i and wraps.
module fabric_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // First requester found at last_i+1, last_i+2, ... (mod NUM_REQ) wins.
  always_comb begin
    logic [IDX_W-1:0] k;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = IDX_W'((int'(last_i) + i) % NUM_REQ);
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = k;
      end
    end
  end

endmodule

// File: rtl/fabric_req_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single-outstanding fabric port.
module fabric_req_arbiter
  import fabric_arb_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ-1:0]       req_write_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  output logic [WIDTH-1:0]         resp_rdata_o,
  output logic                     resp_err_o,
  output logic                     fab_req_valid,
  output logic                     fab_read_req,
  output logic                     fab_write_req,
  output logic [WIDTH-1:0]         fab_write_data,
  input  logic                     fab_resp_valid,
  input  logic [WIDTH-1:0]         fab_read_data,
  output logic                     busy_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_any;

  fabric_rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
    .req_i  (req_valid_i),
    .last_i (last_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

  // Next-state and datapath capture for the transaction FSM.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    cnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        if (rr_any) begin
          grant_d = rr_idx;
          op_d    = req_write_i[rr_idx];
          // Reads carry zero data so the fabric never sees stale write data.
          wdata_d = req_write_i[rr_idx] ? req_wdata_i[rr_idx*WIDTH +: WIDTH] : '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response in the timeout cycle still counts as a clean completion.
        if (fab_resp_valid) begin
          rdata_d = op_q ? '0 : fab_read_data;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        last_d  = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      op_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output decode; response data is zeroed outside the completion pulse.
  always_comb begin
    req_ready_o    = '0;
    resp_valid_o   = '0;
    resp_rdata_o   = '0;
    resp_err_o     = 1'b0;
    fab_req_valid  = 1'b0;
    fab_read_req   = 1'b0;
    fab_write_req  = 1'b0;
    fab_write_data = '0;
    busy_o         = (state_q != ST_IDLE);
    if (state_q == ST_IDLE && !rst) begin
      req_ready_o = rr_gnt;
    end
    if (state_q == ST_ISSUE) begin
      fab_req_valid  = 1'b1;
      fab_write_req  = op_q;
      fab_read_req   = ~op_q;
      fab_write_data = wdata_q;
    end
    if (state_q == ST_RESP) begin
      resp_valid_o[grant_q] = 1'b1;
      resp_rdata_o          = rdata_q;
      resp_err_o            = err_q;
    end
  end

endmodule

// File: tb/tb_fabric_req_arbiter.sv
// Directed bench for fabric_req_arbiter; stimulus and sampling on the falling edge.
module tb_fabric_req_arbiter;

  localparam int WIDTH   = 32;
  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 16;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_REQ-1:0]       req_valid_i = '0;
  logic [NUM_REQ-1:0]       req_write_i = '0;
  logic [NUM_REQ*WIDTH-1:0] req_wdata_i = '0;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [NUM_REQ-1:0]       resp_valid_o;
  logic [WIDTH-1:0]         resp_rdata_o;
  logic                     resp_err_o;
  logic                     fab_req_valid, fab_read_req, fab_write_req;
  logic [WIDTH-1:0]         fab_write_data;
  logic                     fab_resp_valid = 1'b0;
  logic [WIDTH-1:0]         fab_read_data = '0;
  logic                     busy_o;

  int total = 0;
  int bad   = 0;

  fabric_req_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
    .req_ready_o(req_ready_o), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
    .fab_req_valid(fab_req_valid), .fab_read_req(fab_read_req),
    .fab_write_req(fab_write_req), .fab_write_data(fab_write_data),
    .fab_resp_valid(fab_resp_valid), .fab_read_data(fab_read_data),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid_i = 4'hF; fab_resp_valid = 1'b1; fab_read_data = 32'h0BADF00D;
    @(negedge clk); @(negedge clk); #1;
    total++; if (req_ready_o !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
    total++; if (resp_valid_o !== 4'b0000) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0000", resp_valid_o); end
    total++; if ({fab_req_valid, fab_read_req, fab_write_req} !== 3'b000) begin bad++; $display("FAIL reset_fab_strobes got=%b exp=000", {fab_req_valid, fab_read_req, fab_write_req}); end
    total++; if ({busy_o, resp_err_o, resp_rdata_o, fab_write_data} !== '0) begin bad++; $display("FAIL reset_misc busy=%b err=%b rdata=%h wdata=%h exp all 0", busy_o, resp_err_o, resp_rdata_o, fab_write_data); end
    req_valid_i = '0; fab_resp_valid = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b exp=0", busy_o); end
  endtask

  task automatic test_read();
    @(negedge clk);
    req_valid_i = 4'b0001; req_write_i = 4'b0000; #1;
    total++; if (req_ready_o !== 4'b0001) begin bad++; $display("FAIL read_ready got=%b exp=0001", req_ready_o); end
    @(negedge clk); req_valid_i = '0; #1;
    total++; if ({fab_req_valid, fab_read_req, fab_write_req} !== 3'b110) begin bad++; $display("FAIL read_issue got=%b exp=110", {fab_req_valid, fab_read_req, fab_write_req}); end
    total++; if ({busy_o, req_ready_o} !== 5'b10000) begin bad++; $display("FAIL read_issue_busy got=%b exp=10000", {busy_o, req_ready_o}); end
    @(negedge clk); @(negedge clk);
    total++; if ({fab_req_valid, resp_valid_o} !== 5'b0) begin bad++; $display("FAIL read_wait_quiet got=%b exp=00000", {fab_req_valid, resp_valid_o}); end
    @(negedge clk);
    fab_resp_valid = 1'b1; fab_read_data = 32'hDEADBEEF;
    @(negedge clk); fab_resp_valid = 1'b0; fab_read_data = '0; #1;
    total++; if (resp_valid_o !== 4'b0001) begin bad++; $display("FAIL read_resp_valid got=%b exp=0001", resp_valid_o); end
    total++; if (resp_rdata_o !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rdata got=%h exp=deadbeef", resp_rdata_o); end
    total++; if (resp_err_o !== 1'b0) begin bad++; $display("FAIL read_err got=%b exp=0", resp_err_o); end
    @(negedge clk); #1;
    total++; if ({busy_o, resp_valid_o, resp_rdata_o} !== '0) begin bad++; $display("FAIL read_after busy=%b valid=%b rdata=%h exp 0", busy_o, resp_valid_o, resp_rdata_o); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp;
    pulse_reset();
    req_valid_i = 4'hF; req_write_i = '0; fab_resp_valid = 1'b1; fab_read_data = 32'hC0FFEE00;
    for (int g = 0; g < 5; g++) begin
      exp = 4'b0001 << (g % 4);
      #1;
      total++; if (req_ready_o !== exp) begin bad++; $display("FAIL fair_grant%0d got=%b exp=%b", g, req_ready_o, exp); end
      @(negedge clk); #1;
      total++; if ({req_ready_o, fab_req_valid} !== 5'b00001) begin bad++; $display("FAIL fair_issue%0d got=%b exp=00001", g, {req_ready_o, fab_req_valid}); end
      @(negedge clk); #1;
      total++; if ({req_ready_o, resp_valid_o} !== 8'h00) begin bad++; $display("FAIL fair_wait%0d got=%b exp=0", g, {req_ready_o, resp_valid_o}); end
      @(negedge clk); #1;
      total++; if ({req_ready_o, resp_valid_o} !== {4'b0000, exp}) begin bad++; $display("FAIL fair_resp%0d got=%b exp=0000%b", g, {req_ready_o, resp_valid_o}, exp); end
      total++; if (resp_rdata_o !== 32'hC0FFEE00) begin bad++; $display("FAIL fair_rdata%0d got=%h exp=c0ffee00", g, resp_rdata_o); end
      @(negedge clk);
    end
    req_valid_i = '0; fab_resp_valid = 1'b0; fab_read_data = '0;
  endtask

  task automatic test_timeout();
    // Write from requester 2 with a silent fabric.
    @(negedge clk);
    req_valid_i = 4'b0100; req_write_i = 4'b0100; req_wdata_i = {32'h0, 32'hA5A5A5A5, 32'h0, 32'h0}; #1;
    total++; if (req_ready_o !== 4'b0100) begin bad++; $display("FAIL to_ready got=%b exp=0100", req_ready_o); end
    @(negedge clk); req_valid_i = '0; #1;
    total++; if ({fab_write_req, fab_write_data} !== {1'b1, 32'hA5A5A5A5}) begin bad++; $display("FAIL to_issue wr=%b data=%h exp 1 a5a5a5a5", fab_write_req, fab_write_data); end
    @(negedge clk);
    for (int k = 0; k < TIMEOUT; k++) begin
      #1;
      total++; if ({busy_o, resp_valid_o} !== 5'b10000) begin bad++; $display("FAIL to_wait%0d got=%b exp=10000", k, {busy_o, resp_valid_o}); end
      @(negedge clk);
    end
    #1;
    total++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {4'b0100, 1'b1, 32'h0}) begin bad++; $display("FAIL to_resp valid=%b err=%b rdata=%h exp 0100 1 0", resp_valid_o, resp_err_o, resp_rdata_o); end
    @(negedge clk); #1;
    total++; if ({busy_o, resp_err_o} !== 2'b00) begin bad++; $display("FAIL to_after got=%b exp=00", {busy_o, resp_err_o}); end
    // Read from requester 1, response lands in the last counted cycle.
    req_valid_i = 4'b0010; req_write_i = '0;
    @(negedge clk); req_valid_i = '0;
    @(negedge clk);
    for (int k = 0; k < TIMEOUT; k++) begin
      if (k == TIMEOUT - 1) begin fab_resp_valid = 1'b1; fab_read_data = 32'h55AA55AA; end
      @(negedge clk);
    end
    fab_resp_valid = 1'b0; fab_read_data = '0; #1;
    total++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {4'b0010, 1'b0, 32'h55AA55AA}) begin bad++; $display("FAIL to_edge valid=%b err=%b rdata=%h exp 0010 0 55aa55aa", resp_valid_o, resp_err_o, resp_rdata_o); end
    @(negedge clk);
  endtask

  task automatic test_write();
    @(negedge clk);
    req_valid_i = 4'b1000; req_write_i = 4'b1000;
    req_wdata_i = {32'h12345678, 32'h11111111, 32'h22222222, 32'h33333333}; #1;
    total++; if (req_ready_o !== 4'b1000) begin bad++; $display("FAIL wr_ready got=%b exp=1000", req_ready_o); end
    @(negedge clk); req_valid_i = '0; #1;
    total++; if ({fab_req_valid, fab_write_req, fab_read_req, fab_write_data} !== {3'b110, 32'h12345678}) begin bad++; $display("FAIL wr_issue strobes=%b data=%h exp 110 12345678", {fab_req_valid, fab_write_req, fab_read_req}, fab_write_data); end
    @(negedge clk); #1;
    total++; if ({fab_req_valid, fab_write_req, fab_write_data} !== '0) begin bad++; $display("FAIL wr_one_cycle v=%b w=%b data=%h exp 0", fab_req_valid, fab_write_req, fab_write_data); end
    fab_resp_valid = 1'b1; fab_read_data = 32'hFFFFFFFF;
    @(negedge clk); fab_resp_valid = 1'b0; fab_read_data = '0; #1;
    total++; if ({resp_valid_o, resp_err_o, resp_rdata_o} !== {4'b1000, 1'b0, 32'h0}) begin bad++; $display("FAIL wr_resp valid=%b err=%b rdata=%h exp 1000 0 0", resp_valid_o, resp_err_o, resp_rdata_o); end
    @(negedge clk); req_write_i = '0; req_wdata_i = '0;
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    req_valid_i = 4'b0010;
    @(negedge clk); req_valid_i = '0;
    @(negedge clk);
    rst = 1'b1; #1;
    total++; if ({busy_o, resp_valid_o} !== 5'b0) begin bad++; $display("FAIL rw_abandon got=%b exp=00000", {busy_o, resp_valid_o}); end
    @(negedge clk);
    rst = 1'b0; fab_resp_valid = 1'b1; fab_read_data = 32'h11111111;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      total++; if ({busy_o, resp_valid_o, resp_rdata_o} !== '0) begin bad++; $display("FAIL rw_late%0d busy=%b valid=%b rdata=%h exp 0", k, busy_o, resp_valid_o, resp_rdata_o); end
    end
    fab_resp_valid = 1'b0; fab_read_data = '0; req_valid_i = 4'hF; #1;
    total++; if (req_ready_o !== 4'b0001) begin bad++; $display("FAIL rw_next_grant got=%b exp=0001", req_ready_o); end
    req_valid_i = '0;
  endtask

  task automatic test_stray_and_drop();
    @(negedge clk);
    fab_resp_valid = 1'b1; fab_read_data = 32'hBAD0BAD0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      total++; if ({busy_o, fab_req_valid, resp_valid_o, resp_err_o, resp_rdata_o} !== '0) begin bad++; $display("FAIL stray%0d busy=%b fv=%b valid=%b err=%b rdata=%h exp 0", k, busy_o, fab_req_valid, resp_valid_o, resp_err_o, resp_rdata_o); end
    end
    fab_resp_valid = 1'b0; fab_read_data = '0;
    // Requester 0 withdraws before a clock edge: nothing accepted, priority kept.
    req_valid_i = 4'b0001; #1; req_valid_i = '0;
    @(negedge clk); #1;
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL drop_no_accept got=%b exp=0", busy_o); end
    req_valid_i = 4'b0011; #1;
    total++; if (req_ready_o !== 4'b0001) begin bad++; $display("FAIL drop_priority got=%b exp=0001", req_ready_o); end
    req_valid_i = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read();
    test_fairness();
    test_timeout();
    test_write();
    test_reset_in_wait();
    test_stray_and_drop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
